// File: rtl/msdf_if.sv
// Bundle between the online (MSD-first) datapath and the on-the-fly converter.
//   start      : first-digit marker, driven by the digit source
//   z_p, z_n   : positive / negative rails of the current signed digit
//   q          : converted two's-complement result, out_width+1 bits
//   done       : result-valid pulse
//   neg        : result was negative and clamped to zero
//   term       : early-termination request back to the digit source
//   busy       : conversion in progress
// The master modport is the digit source, the slave modport is the converter.
interface msdf_if #(
  parameter int out_width = 16
);
  logic                 start;
  logic                 z_p;
  logic                 z_n;
  logic [out_width:0]   q;
  logic                 done;
  logic                 neg;
  logic                 term;
  logic                 busy;

  modport master (
    output start, z_p, z_n,
    input  q, done, neg, term, busy
  );

  modport slave (
    input  start, z_p, z_n,
    output q, done, neg, term, busy
  );
endinterface

// File: rtl/msdf_otf_converter.sv
// On-the-fly conversion of a most-significant-digit-first signed-digit stream
// into a two's-complement word, with optional ReLU early termination.
//   clk   : clock, all state on the rising edge
//   rst   : asynchronous active-low reset
//   bus   : msdf_if slave (start/z_p/z_n in; q/done/neg/term/busy out)
// Q and QM (= Q - 1) are both kept so that every digit, including -1, is a
// pure shift-and-append; there is never a carry chain in the datapath.
module msdf_otf_converter #(
  parameter int out_width = 16,
  parameter bit relu_en   = 1'b1
) (
  input  logic    clk,
  input  logic    rst,
  msdf_if.slave   bus
);

  localparam int cnt_w = $clog2(out_width + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state, state_nxt;
  logic [out_width:0]   q_reg, q_nxt;
  logic [out_width:0]   qm_reg, qm_nxt;
  logic [out_width:0]   q_base, qm_base;
  logic [cnt_w-1:0]     cnt, cnt_nxt, cnt_base;
  logic [out_width:0]   q_out, q_out_nxt;
  logic                 done_r, done_nxt;
  logic                 neg_r, neg_nxt;
  logic                 term_r, term_nxt;
  logic                 consume;
  logic                 dig_pos, dig_neg;

  // (1,1) falls into neither case and therefore decodes as zero.
  assign dig_pos = bus.z_p & ~bus.z_n;
  assign dig_neg = bus.z_n & ~bus.z_p;

  // A start in any state restarts from the initial Q/QM/counter values, so the
  // start-cycle digit is applied to Q=0, QM=-1 rather than to stale state.
  assign consume  = bus.start | (state == RUN);
  assign q_base   = bus.start ? '0 : q_reg;
  assign qm_base  = bus.start ? '1 : qm_reg;
  assign cnt_base = bus.start ? '0 : cnt;

  always_comb begin
    // NOTE: every variable gets a default first so no path through the block
    // can leave it unassigned and infer a latch.
    state_nxt = state;
    q_nxt     = q_reg;
    qm_nxt    = qm_reg;
    cnt_nxt   = cnt;
    q_out_nxt = q_out;
    neg_nxt   = neg_r;
    done_nxt  = 1'b0;
    term_nxt  = 1'b0;

    if (consume) begin
      if (dig_pos) begin
        q_nxt  = {q_base[out_width-1:0], 1'b1};
        qm_nxt = {q_base[out_width-1:0], 1'b0};
      end else if (dig_neg) begin
        q_nxt  = {qm_base[out_width-1:0], 1'b1};
        qm_nxt = {qm_base[out_width-1:0], 1'b0};
      end else begin
        q_nxt  = {q_base[out_width-1:0], 1'b0};
        qm_nxt = {qm_base[out_width-1:0], 1'b1};
      end
      cnt_nxt = cnt_base + 1'b1;

      // With ReLU on, Q stays zero exactly while every digit so far was zero
      // (a leading +1 makes the running value strictly positive), so Q==0
      // identifies a -1 as the first nonzero digit: the result must be < 0.
      if (relu_en && dig_neg && (q_base == '0)) begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
        term_nxt  = 1'b1;
        neg_nxt   = 1'b1;
        q_out_nxt = '0;
      end else if (cnt_nxt == cnt_w'(out_width)) begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
        neg_nxt   = 1'b0;
        q_out_nxt = q_nxt;
      end else begin
        state_nxt = RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state  <= IDLE;
      q_reg  <= '0;
      qm_reg <= '1;
      cnt    <= '0;
      q_out  <= '0;
      done_r <= 1'b0;
      neg_r  <= 1'b0;
      term_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      q_reg  <= q_nxt;
      qm_reg <= qm_nxt;
      cnt    <= cnt_nxt;
      q_out  <= q_out_nxt;
      done_r <= done_nxt;
      neg_r  <= neg_nxt;
      term_r <= term_nxt;
    end
  end

  assign bus.q    = q_out;
  assign bus.done = done_r;
  assign bus.neg  = neg_r;
  assign bus.term = term_r;
  assign bus.busy = (state == RUN);

endmodule
